// File: rtl/dpi_ctx_pkg.sv
// Shared types and constants for the per-flow DFA context stage.
package dpi_ctx_pkg;

  localparam int DPI_STATE_W = 11;
  localparam int DPI_OFF_W   = 16;
  localparam int DPI_FLOW_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    SAVE   = 2'd3
  } ctx_state_e;

  // Result record as seen by downstream consumers at the default widths.
  typedef struct packed {
    logic [DPI_FLOW_W-1:0] flow;
    logic                  match;
    logic [DPI_OFF_W-1:0]  first_off;
    logic                  err;
  } dpi_res_t;

endpackage

// File: rtl/dpi_ctx_regfile.sv
// Per-flow saved DFA state: async read for LOAD, clear has priority over SAVE.
module dpi_ctx_regfile
  import dpi_ctx_pkg::*;
#(
  parameter int FLOW_W  = DPI_FLOW_W,
  parameter int STATE_W = DPI_STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOW_W-1:0]  rd_flow,
  output logic [STATE_W-1:0] rd_state,
  input  logic               save_en,
  input  logic [FLOW_W-1:0]  save_flow,
  input  logic [STATE_W-1:0] save_state,
  input  logic               clr_en,
  input  logic [FLOW_W-1:0]  clr_flow
);

  localparam int NUM_FLOWS = 2 ** FLOW_W;

  logic [STATE_W-1:0] ctx [NUM_FLOWS];

  assign rd_state = ctx[rd_flow];

  // Both requests resolve per entry, so a clear of one flow never blocks a save of another.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) ctx[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (clr_en && clr_flow == FLOW_W'(i)) begin
          ctx[i] <= '0;
        end else if (save_en && save_flow == FLOW_W'(i)) begin
          ctx[i] <= save_state;
        end
      end
    end
  end

endmodule

// File: rtl/dpi_flow_ctx.sv
// Multiplexes one DFA matcher across many flows by saving/restoring its state per packet.
module dpi_flow_ctx
  import dpi_ctx_pkg::*;
#(
  parameter int FLOW_W  = DPI_FLOW_W,
  parameter int STATE_W = DPI_STATE_W,
  parameter int OFF_W   = DPI_OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [7:0]         in_data,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic [FLOW_W-1:0]  in_flow,
  output logic [7:0]         char_out,
  output logic               char_out_vld,
  output logic [STATE_W-1:0] state_load,
  output logic               state_load_vld,
  input  logic [STATE_W-1:0] mstate_in,
  input  logic               maccept_in,
  input  logic               ctx_clr,
  input  logic [FLOW_W-1:0]  ctx_clr_flow,
  output logic               res_vld,
  output logic [FLOW_W-1:0]  res_flow,
  output logic               res_match,
  output logic [OFF_W-1:0]   res_first_off,
  output logic               res_err,
  output logic               err_drop
);

  ctx_state_e         state_q, state_d;
  logic [FLOW_W-1:0]  cur_flow_q;
  logic [OFF_W-1:0]   offset_q;
  logic [OFF_W-1:0]   first_off_q;
  logic               match_q;
  logic               err_q;
  logic               first_beat_q;
  logic               take;
  logic               abort;
  logic [STATE_W-1:0] rd_state;

  function automatic logic [OFF_W-1:0] sat_inc(input logic [OFF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dpi_ctx_regfile #(
    .FLOW_W  (FLOW_W),
    .STATE_W (STATE_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rd_flow    (cur_flow_q),
    .rd_state   (rd_state),
    .save_en    (state_q == SAVE),
    .save_flow  (cur_flow_q),
    .save_state (mstate_in),
    .clr_en     (ctx_clr),
    .clr_flow   (ctx_clr_flow)
  );

  always_comb begin
    state_d        = state_q;
    in_rdy         = 1'b0;
    take           = 1'b0;
    abort          = 1'b0;
    err_drop       = 1'b0;
    char_out_vld   = 1'b0;
    state_load_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          if (in_sof) begin
            state_d = LOAD;
          end else begin
            in_rdy   = 1'b1;
            err_drop = 1'b1;
          end
        end
      end
      LOAD: begin
        state_load_vld = 1'b1;
        state_d        = STREAM;
      end
      STREAM: begin
        // A fresh sof mid-packet closes this packet; the byte waits for IDLE.
        abort        = in_vld && in_sof && !first_beat_q;
        in_rdy       = !abort;
        take         = in_vld && !abort;
        char_out_vld = take;
        if (abort || (take && in_eof)) state_d = SAVE;
      end
      SAVE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_flow_q   <= '0;
      offset_q     <= '0;
      first_off_q  <= '1;
      match_q      <= 1'b0;
      err_q        <= 1'b0;
      first_beat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_vld && in_sof) cur_flow_q <= in_flow;
        end
        LOAD: begin
          offset_q     <= '0;
          first_off_q  <= '1;
          match_q      <= 1'b0;
          err_q        <= 1'b0;
          first_beat_q <= 1'b1;
        end
        STREAM: begin
          if (take) begin
            if (maccept_in && !match_q) first_off_q <= offset_q;
            if (maccept_in) match_q <= 1'b1;
            offset_q     <= sat_inc(offset_q);
            first_beat_q <= 1'b0;
          end
          if (abort) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign char_out      = (state_q == STREAM) ? in_data : 8'd0;
  assign state_load    = state_load_vld ? rd_state : '0;
  assign res_vld       = (state_q == SAVE);
  assign res_flow      = cur_flow_q;
  assign res_match     = match_q;
  assign res_first_off = first_off_q;
  assign res_err       = err_q;

endmodule

// File: doc/dpi_flow_ctx.md
Name: dpi_flow_ctx

Overview:
- Per-flow context stage that sits directly upstream of a single regex DFA matcher (8-bit char in, 11-bit state load/readback, combinational accept).
- Takes an interleaved packet byte stream tagged with a flow ID. At start-of-packet it loads that flow's saved DFA state into the matcher, then streams the bytes. At end-of-packet it writes the final matcher state back to the context store.
- Emits one result record per packet: match flag and the offset of the first matching byte.
- Lets one matcher instance scan many concurrent TCP/UDP flows whose packets arrive interleaved.

Parameters:
- FLOW_W, 4, flow ID width; NUM_FLOWS = 2**FLOW_W contexts.
- STATE_W, 11, DFA state width; must equal the matcher state width.
- OFF_W, 16, byte-offset counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  input byte valid.
- in_rdy  out  1  input byte accepted when in_vld & in_rdy.
- in_data  in  8  packet byte.
- in_sof  in  1  byte is first of packet.
- in_eof  in  1  byte is last of packet (may coincide with in_sof).
- in_flow  in  FLOW_W  flow ID; sampled only on the sof beat.
- char_out  out  8  to matcher char_in.
- char_out_vld  out  1  to matcher char_in_vld.
- state_load  out  STATE_W  to matcher state_in.
- state_load_vld  out  1  to matcher state_in_vld.
- mstate_in  in  STATE_W  from matcher state_out.
- maccept_in  in  1  from matcher accept_out (combinational, same cycle as char_out_vld).
- ctx_clr  in  1  clear request for one context.
- ctx_clr_flow  in  FLOW_W  context to clear.
- res_vld  out  1  one-cycle result pulse.
- res_flow  out  FLOW_W  flow of the result.
- res_match  out  1  at least one accept seen in the packet.
- res_first_off  out  OFF_W  0-based offset of the first accepting byte; all-ones if none.
- res_err  out  1  packet was aborted by a protocol error.
- err_drop  out  1  one-cycle pulse when a byte is dropped outside a packet.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All NUM_FLOWS contexts are set to 0.
  - Every output is 0 except res_first_off, which resets to all-ones.
  - Reset mid-packet discards the packet; no result is emitted.
- FSM states: IDLE, LOAD, STREAM, SAVE.
- IDLE:
  - If in_vld & in_sof: latch in_flow into cur_flow, hold in_rdy=0 (the sof byte is not consumed yet), go to LOAD.
  - If in_vld & !in_sof: in_rdy=1, the byte is dropped, err_drop pulses.
  - Otherwise in_rdy=0.
- LOAD (exactly 1 cycle):
  - state_load_vld=1 and state_load=ctx[cur_flow].
  - in_rdy=0.
  - Clear offset to 0, clear the match flag, set first_beat=1.
  - Go to STREAM.
- STREAM:
  - in_rdy=1, except when the current beat has in_vld & in_sof & !first_beat.
  - Zero-latency passthrough: char_out=in_data; char_out_vld = in_vld & in_rdy.
  - On an accepted byte:
    - If maccept_in and no match yet, record first_off = offset.
    - Set the match flag if maccept_in.
    - offset increments, saturating at all-ones.
    - first_beat clears.
  - Accepted byte with in_eof: go to SAVE, res_err=0.
  - in_vld & in_sof & !first_beat: abort. The byte is not consumed, go to SAVE with res_err=1. IDLE then picks that byte up as a new packet.
  - in_flow is ignored on non-sof beats.
- SAVE (exactly 1 cycle):
  - The matcher has already registered its final state, so write ctx[cur_flow] <= mstate_in.
  - Assert res_vld with res_flow=cur_flow, res_match, res_first_off and res_err; all are driven from registers.
  - Go to IDLE.
- Per-packet overhead is 3 cycles: the IDLE detect cycle, LOAD and SAVE. A 1-byte packet (sof & eof together) works.
- Context clear:
  - ctx_clr writes 0 to ctx[ctx_clr_flow] at the next edge.
  - If it hits the same flow on the same cycle as a SAVE write, the clear wins.
  - If it hits cur_flow while in STREAM, the later SAVE still writes the final state.
  - If it hits cur_flow on the same cycle as LOAD, LOAD reads the old value (read before write).
- Matcher contract: the matcher must never see state_load_vld and char_out_vld in the same cycle (guaranteed by the FSM).

Decomposition:
- Shared package dpi_ctx_pkg:
  - FSM state enum {IDLE, LOAD, STREAM, SAVE}.
  - Constants DPI_STATE_W=11 and DPI_OFF_W=16.
  - Result record struct {flow, match, first_off, err}.
- One sub-module, dpi_ctx_regfile:
  - NUM_FLOWS x STATE_W register array.
  - One asynchronous read port (for LOAD).
  - One write port with clear-priority muxing between ctx_clr and SAVE.
  - Synchronous reset clears all entries.

Test Plan (stub matcher: next_state = state+1 per byte; accept when next_state == 5):
- Flow 3, 7-byte packet after reset → state_load=0 in LOAD; res_match=1; res_first_off=4; ctx[3]=7; res_err=0.
- Flow 3 again, 2 bytes → state_load=7; res_match=0; res_first_off=16'hFFFF; ctx[3]=9. Interleaved flow 5 packet → state_load=0, so contexts are independent.
- 1-byte packet (sof & eof) on flow 1 → LOAD, one char_out_vld pulse, SAVE; ctx[1]=1; res_vld exactly once, 3 cycles after the IDLE detect cycle.
- Byte with in_sof at packet offset 2 (flow 2) → in_rdy=0 on that beat; res_err=1 and ctx[2]=2; that byte then starts a new packet on its own in_flow.
- Stray byte in IDLE without sof → err_drop=1 for 1 cycle; no char_out_vld. ctx_clr on flow 3 in the same cycle as SAVE of flow 3 → ctx[3]=0.
- Assert rst mid-STREAM → next cycle IDLE, in_rdy=0, all contexts 0, no res_vld; throughout, state_load_vld & char_out_vld is never 1 simultaneously.
